rf_port_ctrl: RTL

Controller in front of the 32x32 register file `rf` (two combinational read ports, one clocked write port). After reset it clears all registers to zero, then shares the rf ports between two requesters (req0: core pipeline, req1: debug/loader) with round-robin arbitration. Each granted transaction reads two registers and optionally writes one. Register x0 is hardwired to zero.

---
 rtl/rf_port_ctrl_pkg.sv | 18 +
 rtl/rf_port_ctrl_rr_arb2.sv | 34 +++
 rtl/rf_port_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rf_port_ctrl_pkg.sv
// Shared types and defaults for the register-file port controller.
package rf_port_ctrl_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rf_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2
    import rf_port_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    req_id_t last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == REQ1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ1;
        end else if (|gnt) begin
            last <= gnt[1] ? REQ1 : REQ0;
        end
    end

endmodule

// File: rtl/rf_port_ctrl.sv
// Clears the register file after reset, then shares its ports between
// two requesters with round-robin arbitration and registered responses.
module rf_port_ctrl
    import rf_port_ctrl_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_rn1,
    input  logic [AW-1:0] req0_rn2,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_wn,
    input  logic [DW-1:0] req0_wd,
    output logic          req0_rsp_valid,
    output logic [DW-1:0] req0_rd1,
    output logic [DW-1:0] req0_rd2,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_rn1,
    input  logic [AW-1:0] req1_rn2,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_wn,
    input  logic [DW-1:0] req1_wd,
    output logic          req1_rsp_valid,
    output logic [DW-1:0] req1_rd1,
    output logic [DW-1:0] req1_rd2,

    output logic [AW-1:0] rf_rn1,
    output logic [AW-1:0] rf_rn2,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_wd,
    output logic          rf_w,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,

    output logic          busy
);

    state_t        state;
    logic [AW-1:0] cnt;
    logic [1:0]    gnt;
    logic          run;

    assign run  = (state == RUN);
    assign busy = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .en  (run),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Writes to x0 still consume the grant but never reach the array.
    always_comb begin
        rf_rn1 = '0;
        rf_rn2 = '0;
        rf_wn  = '0;
        rf_wd  = '0;
        rf_w   = 1'b0;
        unique case (1'b1)
            busy: begin
                rf_wn = cnt;
                rf_w  = 1'b1;
            end
            gnt[0]: begin
                rf_rn1 = req0_rn1;
                rf_rn2 = req0_rn2;
                rf_wn  = req0_wn;
                rf_wd  = req0_wd;
                rf_w   = req0_we && (req0_wn != '0);
            end
            gnt[1]: begin
                rf_rn1 = req1_rn1;
                rf_rn2 = req1_rn2;
                rf_wn  = req1_wn;
                rf_wd  = req1_wd;
                rf_w   = req1_we && (req1_wn != '0);
            end
            default: begin
                rf_w = 1'b0;
            end
        endcase
        if (rst) begin
            rf_w = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_rsp_valid <= 1'b0;
            req0_rd1       <= '0;
            req0_rd2       <= '0;
        end else begin
            req0_rsp_valid <= gnt[0];
            if (gnt[0]) begin
                req0_rd1 <= rf_rd1;
                req0_rd2 <= rf_rd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req1_rsp_valid <= 1'b0;
            req1_rd1       <= '0;
            req1_rd2       <= '0;
        end else begin
            req1_rsp_valid <= gnt[1];
            if (gnt[1]) begin
                req1_rd1 <= rf_rd1;
                req1_rd2 <= rf_rd2;
            end
        end
    end

endmodule
